// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Purpose  : Branch target and condition evaluation with an optional
//            hardware return stack for call/return.
// Config   : define BRANCH_STACK_EN to compile in the return stack;
//            without it calls act as jumps and returns are never taken.
// Revision : 1.0  initial release
// ============================================================================
module branch_unit #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cins,
  input  logic [7:0]        databus,
  input  logic [ADDR_W-1:0] pcin,
  input  logic              pcc,
  input  logic              zflag,
  input  logic              oflag,
  input  logic              cflag,
  input  logic              sflag,
  input  logic              oe,
  output logic              pcoe,
  output logic [ADDR_W-1:0] pcout,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam logic [1:0] KIND_JUMP = 2'b00;
  localparam logic [1:0] KIND_CALL = 2'b01;
  localparam logic [1:0] KIND_RET  = 2'b10;

  // Reject parameter sets the operand/stack layout cannot support
  if (ADDR_W < 16 || (ADDR_W % 8) != 0 || STACK_DEPTH < 2) begin : g_param_check
    $error("branch_unit: ADDR_W must be a multiple of 8 >= 16, STACK_DEPTH >= 2");
  end

  logic [ADDR_W-9:0] opnd;
  logic [ADDR_W-1:0] imm;
  logic [ADDR_W-1:0] target;
  logic [1:0]        kind;
  logic              cond;
  logic              taken;
  logic              lt;

  assign imm    = {opnd, databus};
  assign target = cins[4] ? pcin + imm : imm;
  assign kind   = cins[6:5];
  assign lt     = oflag ^ sflag;
  assign taken  = oe & cins[7] & cond;

  // Condition select decode; codes 11..15 are never true
  always_comb begin
    cond = 1'b0;
    case (cins[3:0])
      4'd0:    cond = 1'b1;
      4'd1:    cond = zflag;
      4'd2:    cond = ~zflag;
      4'd3:    cond = cflag;
      4'd4:    cond = cflag | zflag;
      4'd5:    cond = ~(cflag | zflag);
      4'd6:    cond = ~cflag;
      4'd7:    cond = lt;
      4'd8:    cond = lt | zflag;
      4'd9:    cond = ~lt & ~zflag;
      4'd10:   cond = ~lt;
      default: cond = 1'b0;
    endcase
  end

  // Operand register: shift in one byte per pcc cycle, oldest byte on top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) opnd <= '0;
    else if (pcc) opnd <= imm[ADDR_W-9:0];
  end

`ifdef BRANCH_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IX_W = $clog2(STACK_DEPTH);

  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [IX_W-1:0]   top_ix;
  logic [IX_W-1:0]   push_ix;
  logic [ADDR_W-1:0] next_pc;
  logic              push;
  logic              pop;
  logic              fault;

  assign top_ix      = IX_W'(sp - SP_W'(1));
  assign push_ix     = IX_W'(sp);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign pcout       = pcoe ? next_pc : '0;

  // Resolve the branch: calls need room, returns need an entry
  always_comb begin
    pcoe    = 1'b0;
    next_pc = target;
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
    case (kind)
      KIND_JUMP: pcoe = taken;
      KIND_CALL: begin
        if (taken) begin
          if (stack_full) fault = 1'b1;
          else begin
            pcoe = 1'b1;
            push = 1'b1;
          end
        end
      end
      KIND_RET: begin
        next_pc = stack_mem[top_ix];
        if (taken) begin
          if (stack_empty) fault = 1'b1;
          else begin
            pcoe = 1'b1;
            pop  = 1'b1;
          end
        end
      end
      default: pcoe = 1'b0;
    endcase
  end

  // Stack pointer and sticky overflow/underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
      if (fault) stack_err <= 1'b1;
    end
  end

  // Return-address storage; contents are meaningless once sp is cleared
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_ix] <= pcin;
  end
`else
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;
  assign pcout       = pcoe ? target : '0;

  // Without a stack a call is a plain jump and a return has nowhere to go
  always_comb begin
    pcoe = 1'b0;
    case (kind)
      KIND_JUMP: pcoe = taken;
      KIND_CALL: pcoe = taken;
      KIND_RET:  pcoe = 1'b0;
      default:   pcoe = 1'b0;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit
// Purpose  : Scoreboard bench for branch_unit; expectations come from a
//            queue-based model of the return stack and condition table.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_unit;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;
`ifdef BRANCH_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        cins = '0;
  logic [7:0]        databus = '0;
  logic [ADDR_W-1:0] pcin = '0;
  logic              pcc = 1'b0;
  logic              zflag = 1'b0, oflag = 1'b0, cflag = 1'b0, sflag = 1'b0;
  logic              oe = 1'b0;
  logic              pcoe;
  logic [ADDR_W-1:0] pcout;
  logic              stack_full, stack_empty, stack_err;

  branch_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cins(cins), .databus(databus), .pcin(pcin),
    .pcc(pcc), .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
    .oe(oe), .pcoe(pcoe), .pcout(pcout), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              pcoe;
    logic [ADDR_W-1:0] pcout;
    logic              full;
    logic              empty;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // reference state
  logic [ADDR_W-9:0] m_opnd = '0;
  logic [ADDR_W-1:0] m_stk[$];
  bit                m_err = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit cond_ok(input logic [3:0] sel, input bit z, input bit o, input bit c, input bit s);
    bit lt;
    bit t[16];
    lt = o ^ s;
    t = '{default: 1'b0};
    t[0] = 1'b1;  t[1] = z;        t[2] = !z;          t[3] = c;
    t[4] = c | z; t[5] = !(c | z); t[6] = !c;          t[7] = lt;
    t[8] = lt | z; t[9] = !lt && !z; t[10] = !lt;
    return t[sel];
  endfunction

  function automatic void model_reset();
    m_opnd = '0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show for it
  task automatic step(input logic [7:0] c, input logic [7:0] d, input logic [ADDR_W-1:0] pc,
                      input bit p, input bit e, input logic [3:0] f);
    exp_t x;
    logic [ADDR_W-1:0] imm, tgt;
    bit tk, do_push, do_pop;
    @(posedge clk); #1;
    cins = c; databus = d; pcin = pc; pcc = p; oe = e;
    {zflag, oflag, cflag, sflag} = f;
    imm = {m_opnd, d};
    tgt = c[4] ? pc + imm : imm;
    tk = e && c[7] && cond_ok(c[3:0], f[3], f[2], f[1], f[0]);
    x.pcoe  = 1'b0;
    x.pcout = '0;
    x.empty = !STK_EN || (m_stk.size() == 0);
    x.full  = STK_EN && (m_stk.size() == DEPTH);
    x.err   = m_err;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (tk) begin
      case (c[6:5])
        2'b00: begin x.pcoe = 1'b1; x.pcout = tgt; end
        2'b01: begin
          if (!STK_EN) begin x.pcoe = 1'b1; x.pcout = tgt; end
          else if (m_stk.size() < DEPTH) begin x.pcoe = 1'b1; x.pcout = tgt; do_push = 1'b1; end
          else m_err = 1'b1;
        end
        2'b10: begin
          if (STK_EN) begin
            if (m_stk.size() > 0) begin x.pcoe = 1'b1; x.pcout = m_stk[$]; do_pop = 1'b1; end
            else m_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
    sb.push_back(x);
    if (do_push) m_stk.push_back(pc);
    if (do_pop) void'(m_stk.pop_back());
    if (p) m_opnd = imm[ADDR_W-9:0];
  endtask

  // Reset pulled low between edges while a call is being presented
  task automatic async_reset_during_call();
    @(posedge clk); #1;
    cins = 8'hA0; databus = 8'h55; pcin = 16'h0777; pcc = 1'b0; oe = 1'b1;
    {zflag, oflag, cflag, sflag} = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_empty", {31'd0, stack_empty}, 32'd1);
    chk("rst_async_full", {31'd0, stack_full}, 32'd0);
    chk("rst_async_err", {31'd0, stack_err}, 32'd0);
    chk("rst_async_pcoe", {31'd0, pcoe}, 32'd1);
    chk("rst_async_pcout", {16'd0, pcout}, 32'h0055);
    oe = 1'b0; cins = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare the queued expectation against the DUT mid-cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("pcoe", {31'd0, pcoe}, {31'd0, x.pcoe});
        chk("pcout", {16'd0, pcout}, {16'd0, x.pcout});
        chk("stack_full", {31'd0, stack_full}, {31'd0, x.full});
        chk("stack_empty", {31'd0, stack_empty}, {31'd0, x.empty});
        chk("stack_err", {31'd0, stack_err}, {31'd0, x.err});
      end
    end
  end

  initial begin
    logic [7:0] rc;
    logic [7:0] rd;
    logic [3:0] rf;
    bit         rp, re;
    logic [ADDR_W-1:0] rpc;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // post-reset idle state
    step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);
    // absolute jump 0x1234
    step(8'h00, 8'h12, 16'h0000, 1'b1, 1'b0, 4'b0000);
    step(8'h80, 8'h34, 16'h0000, 1'b0, 1'b1, 4'b0000);
    // relative wrap: 0x0020 + 0xFFF0
    step(8'h00, 8'hFF, 16'h0000, 1'b1, 1'b0, 4'b0000);
    step(8'h90, 8'hF0, 16'h0020, 1'b0, 1'b1, 4'b0000);
    // conditional on z with z=0
    step(8'h81, 8'h00, 16'h0000, 1'b0, 1'b1, 4'b0000);
    step(8'h82, 8'h00, 16'h0000, 1'b0, 1'b1, 4'b0000);
    // reserved kind never taken
    step(8'hE0, 8'h00, 16'h0000, 1'b0, 1'b1, 4'b0000);
    // call 0x2000 from 0x0103, then return
    step(8'h00, 8'h20, 16'h0000, 1'b1, 1'b0, 4'b0000);
    step(8'hA0, 8'h00, 16'h0103, 1'b0, 1'b1, 4'b0000);
    step(8'hC0, 8'h00, 16'h2000, 1'b0, 1'b1, 4'b0000);
    step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);
    // overflow by one, then drain and underflow by one
    for (int i = 0; i <= DEPTH; i++)
      step(8'hA0, i[7:0], ADDR_W'(16'h0400 + i), 1'b0, 1'b1, 4'b0000);
    step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i <= DEPTH; i++)
      step(8'hC0, 8'h00, 16'h0000, 1'b0, 1'b1, 4'b0000);
    step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);
    // shift and call in the same cycle, then jump using the new operand
    step(8'hA0, 8'h77, 16'h0555, 1'b1, 1'b1, 4'b0000);
    step(8'h80, 8'h01, 16'h0000, 1'b0, 1'b1, 4'b0000);
    step(8'hA0, 8'h10, 16'h0666, 1'b0, 1'b1, 4'b0000);
    async_reset_during_call();
    step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);

    for (int n = 0; n < 400; n++) begin
      rc = 8'($urandom);
      rc[7] = ($urandom_range(0, 3) != 0);
      rd = 8'($urandom);
      rf = 4'($urandom);
      rp = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 3) != 0);
      rpc = ADDR_W'($urandom);
      step(rc, rd, rpc, rp, re, rf);
      if (n == 200) begin
        async_reset_during_call();
        step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);
      end
    end

    step(8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter ADDR_W, default 16: program-counter width; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter STACK_DEPTH, default 8: return-stack entries; SHALL be at least 2.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port cins  input  8  control word: [7] branch-class, [6:5] kind (00 jump, 01 call, 10 return, 11 reserved), [4] relative, [3:0] condition select.
REQ-006 Port databus  input  8  operand byte.
REQ-007 Port pcin  input  ADDR_W  current PC (address of next instruction).
REQ-008 Port pcc  input  1  shift databus into the operand register.
REQ-009 Ports zflag, oflag, cflag, sflag  input  1 each  ALU flags.
REQ-010 Port oe  input  1  evaluate-branch strobe.
REQ-011 Port pcoe  output  1  branch taken; PC loads pcout.
REQ-012 Port pcout  output  ADDR_W  branch target.
REQ-013 Ports stack_full, stack_empty, stack_err  output  1 each  return-stack status; stack_err is sticky.

Function
REQ-014 Operand register opnd (ADDR_W-8 bits) SHALL shift left by 8 and load databus into its low byte on each clk edge with pcc=1.
REQ-015 Absolute target SHALL be {opnd, databus}; relative target SHALL be pcin + {opnd, databus}, modulo 2^ADDR_W, carry discarded.
REQ-016 Condition select SHALL be: 0 always, 1 z, 2 !z, 3 c, 4 c|z, 5 !(c|z), 6 !c, 7 o^s, 8 (o^s)|z, 9 !(o^s)&!z, 10 !(o^s); 11-15 never.
REQ-017 taken = oe & cins[7] & cond; kind 11 SHALL never be taken.
REQ-018 pcoe and pcout SHALL be combinational, same cycle as oe; pcout SHALL be 0 whenever pcoe=0.
REQ-019 Jump taken: pcout = selected target.
REQ-020 Call taken, stack not full: pcout = selected target; pcin pushed on the same clk edge.
REQ-021 Return taken, stack not empty: pcout = top-of-stack (cins[4] ignored); entry popped on the same clk edge.
REQ-022 Call with stack full or return with stack empty: pcoe SHALL be 0, stack unchanged, stack_err set on that edge.
REQ-023 Stack pointer SHALL range 0..STACK_DEPTH; stack_empty = (sp==0), stack_full = (sp==STACK_DEPTH); never wraps.
REQ-024 pcc and oe in the same cycle: target uses the pre-edge opnd; shift and push/pop both occur on that edge.
REQ-025 oe held high over several cycles SHALL push/pop once per edge while taken.

Reset
REQ-026 rst_n low SHALL immediately clear opnd, sp and stack_err, independent of clk; stack entry contents are don't-care.
REQ-027 After reset: pcoe=0, pcout=0 (with oe=0), stack_empty=1, stack_full=0, stack_err=0.
REQ-028 Reset mid-call or mid-return SHALL discard the pending push/pop.

Configuration
REQ-029 Macro BRANCH_STACK_EN defined: return stack and REQ-020..REQ-025 stack behaviour compiled in.
REQ-030 Macro BRANCH_STACK_EN undefined: no stack storage; call behaves as jump; return is never taken; stack_empty=1, stack_full=0, stack_err=0 constant.

Verification
REQ-031 Reset, pcc with 0x12 then databus=0x34, cins=0x80, oe=1 -> pcoe=1, pcout=0x1234.
REQ-032 opnd=0xFF, databus=0xF0, pcin=0x0020, cins=0x90, oe=1 -> pcout=0x0010 (wrap).
REQ-033 zflag=0, cins=0x81, oe=1 -> pcoe=0, pcout=0x0000; cins=0x82 -> pcoe=1.
REQ-034 Call from pcin=0x0103 to 0x2000, then return with cins=0xC0 -> pcout=0x0103, stack_empty=1 afterwards.
REQ-035 STACK_DEPTH+1 calls -> last call pcoe=0, stack_full=1, stack_err=1; return on empty stack -> pcoe=0, stack_err stays 1 until rst_n low.
REQ-036 Assert rst_n low between clk edges while oe=1 with a call -> sp=0, stack_err=0 immediately; no push occurs.
